fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives the write and read ports of the team's single-clock dual-port FIFO RAM (registered read, 1-cycle latency). Accepts push/pop requests from client logic and manages the write/read pointers, occupancy and flags. Presents popped data with a valid strobe aligned to the RAM's registered read output. Sits between client logic and the RAM instance inside the synchronous FIFO top level.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_ptr.sv | 25 ++
 rtl/fifo_ctrl.sv | 96 +++++++++
 tb/tb_fifo_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing defaults and helpers for the synchronous FIFO controller.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_W_DEF      = ADDR_WIDTH_DEF + 1;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments modulo 2**PTR_W, synchronous active-high reset.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [PTR_W-1:0] ptr_o
);
  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a single-clock dual-port FIFO RAM with registered read.
// Optional sticky overflow/underflow outputs: define FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);
  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] AF_LEVEL = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;
  logic             pop_valid_q;

  // Flags come from the pre-edge pointers, so a same-cycle pop never frees room for a push.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= AF_LEVEL);

  assign push_ok = push && !full && !rst;
  assign pop_ok  = pop && !empty && !rst;

  assign mem_wen   = push_ok;
  assign mem_ren   = pop_ok;
  assign mem_waddr = wr_ptr[PTR_W-2:0];
  assign mem_raddr = rd_ptr[PTR_W-2:0];
  assign mem_wdata = push_data;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push_ok),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop_ok),
    .ptr_o (rd_ptr)
  );

  // Valid strobe lines up with the RAM's one-cycle registered read.
  always_ff @(posedge clk) begin
    if (rst) pop_valid_q <= 1'b0;
    else     pop_valid_q <= pop_ok;
  end

  assign pop_valid = pop_valid_q;
  assign pop_data  = mem_rdata;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (push && full);
      udf_q <= udf_q | (pop && empty);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (DEPTH=4, AF_MARGIN=1) with a behavioural registered-read RAM.
module tb_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0, pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] pop_data, mem_wdata, mem_rdata;
  logic          pop_valid, full, empty, almost_full, mem_wen, mem_ren;
  logic [AW:0]   count;
  logic [AW-1:0] mem_waddr, mem_raddr;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_MARGIN(1)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .mem_waddr(mem_waddr),
    .mem_raddr(mem_raddr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_raddr];
  end

  // Reference model: FIFO contents, model pointers and the popped-data scoreboard.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            exp_v = 1'b0;
  bit            acc_push, acc_pop;
  int            wr_idx = 0, rd_idx = 0;

  typedef struct {
    bit            push, pop;
    logic [DW-1:0] data;
    bit            wen, ren;
    int            cnt;
    bit            full, empty, af;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request set and check the pre-edge combinational outputs against the model.
  task automatic drive(input bit ph, input bit pp, input logic [DW-1:0] d);
    int sz;
    push = ph; pop = pp; push_data = d;
    #1;
    sz = model_q.size();
    acc_push = ph && (sz < DEPTH);
    acc_pop  = pp && (sz > 0);
    chk("mem_wen", mem_wen, acc_push);
    chk("mem_ren", mem_ren, acc_pop);
    chk("count", count, sz);
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("almost_full", almost_full, sz >= DEPTH - 1);
    if (acc_push) begin
      chk("mem_waddr", mem_waddr, wr_idx);
      chk("mem_wdata", mem_wdata, d);
    end
    if (acc_pop) chk("mem_raddr", mem_raddr, rd_idx);
  endtask

  // Advance one clock, update the model and check the read-side result.
  task automatic clock();
    if (acc_pop) begin
      exp_q.push_back(model_q.pop_front());
      rd_idx = (rd_idx + 1) % DEPTH;
    end
    if (acc_push) begin
      model_q.push_back(push_data);
      wr_idx = (wr_idx + 1) % DEPTH;
    end
    exp_v = acc_pop;
    @(posedge clk); #1;
    chk("pop_valid", pop_valid, exp_v);
    if (exp_v && exp_q.size() > 0) chk("pop_data", pop_data, exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic step(input bit ph, input bit pp, input logic [DW-1:0] d);
    drive(ph, pp, d);
    clock();
  endtask

  // Two reset cycles with both requests held high; contents and pending reads are discarded.
  task automatic do_reset();
    rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 8'hEE;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_mem_wen", mem_wen, 1'b0);
      chk("rst_mem_ren", mem_ren, 1'b0);
      @(posedge clk); #1;
      chk("rst_pop_valid", pop_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_af", almost_full, 1'b0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_underflow", underflow, 1'b0);
`endif
      @(negedge clk);
    end
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    model_q.delete(); exp_q.delete();
    exp_v = 1'b0; wr_idx = 0; rd_idx = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    //            push pop data   wen ren cnt full empty af
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 8'hBB, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0};

    do_reset();

    // Fill, overfill, drain, underflow, then simultaneous push+pop at empty.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].push, vecs[i].pop, vecs[i].data);
      chk($sformatf("vec%0d_wen", i), mem_wen, vecs[i].wen);
      chk($sformatf("vec%0d_ren", i), mem_ren, vecs[i].ren);
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_full", i), full, vecs[i].full);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      chk($sformatf("vec%0d_af", i), almost_full, vecs[i].af);
      clock();
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("after_vec_count", count, 1);
    clock();

    // Steady push+pop at count=2, then push+pop while full.
    do_reset();
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'h03 + 8'(i));
    drive(1'b0, 1'b0, 8'h00);
    chk("steady_count", count, 2);
    clock();
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b1, 8'h12);
    drive(1'b0, 1'b0, 8'h00);
    chk("full_pushpop_count", count, 3);
    clock();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h77);
    drive(1'b0, 1'b0, 8'h00);
    chk("empty_pushpop_count", count, 1);
    chk("empty_pushpop_valid", pop_valid, 1'b0);
    clock();
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Wrap-around: full with wr_ptr=7, rd_ptr=3.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h90 + 8'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
    drive(1'b0, 1'b0, 8'h00);
    chk("wrap_full", full, 1'b1);
    chk("wrap_waddr", mem_waddr, 3);
    chk("wrap_raddr", mem_raddr, 3);
    clock();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Reset right after accepted pops, then a clean round trip.
    do_reset();
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h34);
    step(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    acc_pop = 1'b0; acc_push = 1'b0;
    do_reset();
    step(1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    do_reset();
    step(1'b0, 1'b1, 8'h00);
    chk("underflow_set", underflow, 1'b1);
    chk("overflow_clear", overflow, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    chk("underflow_sticky", underflow, 1'b1);
    chk("overflow_not_yet", overflow, 1'b0);
    step(1'b1, 1'b0, 8'hCF);
    chk("overflow_set", overflow, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("overflow_sticky", overflow, 1'b1);
    chk("underflow_still", underflow, 1'b1);
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
